// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and the arbiter.
//   req       : request vector, bit i = requester i
//   done      : current grantee releases the grant
//   gnt_valid : a grant is active
//   gnt_idx   : current grantee index, drives decoder {x,y}
//   gnt_new   : first cycle of each new grant
//   timeout   : forced-release pulse
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               gnt_valid;
    idx_t               gnt_idx;
    logic               gnt_new;
    logic               timeout;

    modport master (
        output req, done,
        input  gnt_valid, gnt_idx, gnt_new, timeout
    );

    modport slave (
        input  req, done,
        output gnt_valid, gnt_idx, gnt_new, timeout
    );
endinterface

// File: rtl/rr_pick4.sv
// Rotating priority search: first set bit of req scanning start, start+1, ... mod 4.
//   req   : request vector
//   start : index scanned first
//   idx   : first requesting index found (start when none)
//   any   : at least one request is set
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               start,
    output idx_t               idx,
    output logic               any
);

    idx_t cand;

    always_comb begin
        idx  = start;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // 2-bit add wraps 3 -> 0 naturally
            cand = start + IDX_W'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters feeding the 2-to-4 decoder stage.
// Grants are held until done, request withdrawal, or (optionally) a hold timeout,
// then handed off back-to-back to the next requester in rotating order.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   arb  : rr_arbiter4_if.slave (req/done in, gnt_valid/gnt_idx/gnt_new/timeout out)
// Build option: define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles;
// otherwise timeout is constant 0.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  arb
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    arb_state_t        state_q, state_d;
    idx_t              gnt_idx_q, gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              gnt_new_q, gnt_new_d;
    logic              timeout_q, timeout_d;
    idx_t              last_ptr_q, last_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    idx_t start_c;
    idx_t pick_idx_c;
    logic pick_any_c;
    logic hold_hit_c;
    logic release_c;

    // One shared search: IDLE rotates from last_ptr, GRANT from the current grantee
    assign start_c = (state_q == IDLE) ? idx_t'(last_ptr_q + idx_t'(1))
                                       : idx_t'(gnt_idx_q + idx_t'(1));

    rr_pick4 u_pick (
        .req   (arb.req),
        .start (start_c),
        .idx   (pick_idx_c),
        .any   (pick_any_c)
    );

    assign hold_hit_c = TIMEOUT_EN && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign release_c  = arb.done || !arb.req[gnt_idx_q] || hold_hit_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
            timeout_q   <= 1'b0;
            last_ptr_q  <= idx_t'(NUM_REQ - 1);
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_new_q   <= gnt_new_d;
            timeout_q   <= timeout_d;
            last_ptr_q  <= last_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        gnt_new_d   = 1'b0;
        timeout_d   = 1'b0;
        last_ptr_d  = last_ptr_q;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                if (pick_any_c) begin
                    state_d     = GRANT;
                    gnt_idx_d   = pick_idx_c;
                    gnt_valid_d = 1'b1;
                    gnt_new_d   = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    last_ptr_d = gnt_idx_q;
                    hold_cnt_d = '0;
                    timeout_d  = hold_hit_c;
                    if (pick_any_c) begin
                        gnt_idx_d = pick_idx_c;
                        gnt_new_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign arb.gnt_valid = gnt_valid_q;
    assign arb.gnt_idx   = gnt_idx_q;
    assign arb.gnt_new   = gnt_new_q;
    assign arb.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD=4); covers the timeout path when
// ARB_TIMEOUT_EN is defined and checks it stays silent otherwise.
module tb_rr_arbiter4;
    import arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_gnt(input string tag, input logic v, input logic [1:0] idx,
                             input logic nw, input logic to);
        check({tag, "_valid"},   8'(bus.gnt_valid), 8'(v));
        check({tag, "_idx"},     8'(bus.gnt_idx),   8'(idx));
        check({tag, "_new"},     8'(bus.gnt_new),   8'(nw));
        check({tag, "_timeout"}, 8'(bus.timeout),   8'(to));
    endtask

    initial begin
        logic [1:0] order [4];
        logic [3:0] exp_dec [4];
        logic [3:0] dec;
        order   = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_dec = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset state
        tick();
        tick();
        check_gnt("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // First grant to 0, then back-to-back handoff to 2 on done
        bus.req = 4'b0101;
        tick();
        check_gnt("first_grant", 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        check_gnt("first_hold", 1'b1, 2'd0, 1'b0, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_gnt("handoff", 1'b1, 2'd2, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_gnt("drop_idle", 1'b0, 2'd2, 1'b0, 1'b0);

        // Full rotation with all requesting
        rst     = 1'b1;
        bus.req = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        check_gnt("rot_start", 1'b1, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rot_hold_a_valid", 8'(bus.gnt_valid), 8'd1);
            tick();
            check("rot_hold_b_new", 8'(bus.gnt_new), 8'd0);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check_gnt("rot_next", 1'b1, order[k], 1'b1, 1'b0);
        end

        // Grantee 0 drops; sole requester 3 granted, then re-granted on done
        bus.req = 4'b1000;
        tick();
        check_gnt("sole_grant", 1'b1, 2'd3, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_gnt("sole_regrant", 1'b1, 2'd3, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_gnt("sole_drop", 1'b0, 2'd3, 1'b0, 1'b0);

        // done while idle is ignored
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_gnt("idle_done", 1'b0, 2'd3, 1'b0, 1'b0);

        // Grant to 1, reset mid-grant
        bus.req = 4'b0010;
        tick();
        check_gnt("pre_rst_grant", 1'b1, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_gnt("mid_rst", 1'b0, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1010;
        tick();
        check_gnt("post_rst_grant", 1'b1, 2'd1, 1'b1, 1'b0);
        // Non-grantee request change does not disturb the grant
        bus.req = 4'b1011;
        tick();
        check_gnt("other_req_change", 1'b1, 2'd1, 1'b0, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_gnt("clear", 1'b0, 2'd1, 1'b0, 1'b0);

        // Hold limit behaviour
        rst     = 1'b1;
        bus.req = 4'b0011;
        tick();
        rst = 1'b0;
        tick();
        check_gnt("to_grant0", 1'b1, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check_gnt("to_hold0", 1'b1, 2'd0, 1'b0, 1'b0);
        end
        tick();
        check_gnt("to_force1", 1'b1, 2'd1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_gnt("to_hold1", 1'b1, 2'd1, 1'b0, 1'b0);
        end
        tick();
        check_gnt("to_force0", 1'b1, 2'd0, 1'b1, 1'b1);
`else
        for (int k = 0; k < 8; k++) begin
            tick();
            check_gnt("no_to_hold", 1'b1, 2'd0, 1'b0, 1'b0);
        end
`endif
        bus.req = 4'b0000;
        tick();
        check("to_clear_valid", 8'(bus.gnt_valid), 8'd0);

        // Decoder hookup: index drives {x,y}, one-hot {a,b,c,d}
        for (int i = 0; i < 4; i++) begin
            bus.req = 4'b0001 << i;
            tick();
            dec = 4'b1000 >> bus.gnt_idx;
            check("dec_valid", 8'(bus.gnt_valid), 8'd1);
            check("dec_onehot", 8'(dec), 8'(exp_dec[i]));
            bus.req = 4'b0000;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
